// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared types and constants for the BCD-to-binary converter.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam int LARGURA_BIN = 11;
  localparam int ITERACOES   = 11;
  localparam logic [LARGURA_BIN-1:0] VALOR_ERRO = 11'h7FF;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    CONVERTE  = 2'd1,
    CONCLUIDO = 2'd2
  } estado_t;

endpackage
`default_nettype wire

// File: rtl/bcd_para_binario_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_para_binario_if
// Purpose  : Digit/start request and result bundle of the converter.
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_para_binario_if;
  logic [3:0]  centena;
  logic [3:0]  dezena;
  logic [3:0]  unidade;
  logic        iniciar;
  logic [10:0] binario;
  logic        pronto;
  logic        ocupado;
  logic        erro;

  modport master (output centena, dezena, unidade, iniciar,
                  input  binario, pronto, ocupado, erro);
  modport slave  (input  centena, dezena, unidade, iniciar,
                  output binario, pronto, ocupado, erro);
endinterface
`default_nettype wire

// File: rtl/bcd_para_binario_corretor_digito.sv
`default_nettype none
// ============================================================================
// Module   : corretor_digito
// Purpose  : Reverse double-dabble nibble correction (subtract 3 if >= 8).
// Revision : 1.0 - initial release
// ============================================================================
module corretor_digito (
  input  wire logic [3:0] i_digito,
  output logic      [3:0] o_digito
);
  assign o_digito = (i_digito >= 4'd8) ? (i_digito - 4'd3) : i_digito;
endmodule
`default_nettype wire

// File: rtl/bcd_para_binario.sv
`default_nettype none
// ============================================================================
// Module   : bcd_para_binario
// Purpose  : Sequential 3-digit BCD to 11-bit binary converter (reverse
//            double-dabble, 12-cycle latency). BCD_PARA_BINARIO_VALIDACAO_EN
//            enables digit validation and the erro flag.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_para_binario
  import bcd_pkg::*;
(
  input  wire logic        clock,
  input  wire logic        reset,
  bcd_para_binario_if.slave bus
);

  localparam logic [3:0] c_ITER_FIM = 4'(ITERACOES);

  estado_t                r_estado;
  logic [22:0]            r_desloc;
  logic [3:0]             r_cont;
  logic [LARGURA_BIN-1:0] r_binario;
  logic                   r_pronto;
  logic                   r_ocupado;

  logic [22:0] w_deslocado;
  logic [3:0]  w_cent_corr;
  logic [3:0]  w_dez_corr;
  logic [3:0]  w_uni_corr;
  logic        w_aceita;
  logic        w_invalido_capturado;

  assign w_deslocado = r_desloc >> 1;
  assign w_aceita    = (r_estado != CONVERTE) && bus.iniciar;

  corretor_digito u_corr_cent (.i_digito(w_deslocado[22:19]), .o_digito(w_cent_corr));
  corretor_digito u_corr_dez  (.i_digito(w_deslocado[18:15]), .o_digito(w_dez_corr));
  corretor_digito u_corr_uni  (.i_digito(w_deslocado[14:11]), .o_digito(w_uni_corr));

`ifdef BCD_PARA_BINARIO_VALIDACAO_EN
  logic r_invalido;
  logic r_erro;
  logic w_digito_invalido;

  assign w_digito_invalido = (bus.centena > 4'd9) || (bus.dezena > 4'd9) ||
                             (bus.unidade > 4'd9);
  assign w_invalido_capturado = r_invalido;
  assign bus.erro = r_erro;

  // erro is sticky until the next accepted start
  always_ff @(posedge clock) begin
    if (reset) begin
      r_invalido <= 1'b0;
      r_erro     <= 1'b0;
    end else if (w_aceita) begin
      r_invalido <= w_digito_invalido;
      r_erro     <= 1'b0;
    end else if ((r_estado == CONVERTE) && r_invalido) begin
      r_invalido <= 1'b0;
      r_erro     <= 1'b1;
    end
  end
`else
  assign w_invalido_capturado = 1'b0;
  assign bus.erro = 1'b0;
`endif

  // CONCLUIDO accepts a new start directly to keep the 13-cycle period
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado  <= OCIOSO;
      r_desloc  <= '0;
      r_cont    <= '0;
      r_binario <= '0;
      r_pronto  <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      case (r_estado)
        CONVERTE: begin
          if (w_invalido_capturado) begin
            r_binario <= VALOR_ERRO;
            r_pronto  <= 1'b1;
            r_ocupado <= 1'b0;
            r_estado  <= CONCLUIDO;
          end else if (r_cont == c_ITER_FIM) begin
            r_binario <= r_desloc[LARGURA_BIN-1:0];
            r_pronto  <= 1'b1;
            r_ocupado <= 1'b0;
            r_estado  <= CONCLUIDO;
          end else begin
            r_desloc <= {w_cent_corr, w_dez_corr, w_uni_corr, w_deslocado[10:0]};
            r_cont   <= r_cont + 4'd1;
          end
        end
        default: begin
          r_pronto <= 1'b0;
          if (w_aceita) begin
            r_desloc  <= {bus.centena, bus.dezena, bus.unidade, 11'd0};
            r_cont    <= '0;
            r_ocupado <= 1'b1;
            r_estado  <= CONVERTE;
          end else begin
            r_estado <= OCIOSO;
          end
        end
      endcase
    end
  end

  assign bus.binario = r_binario;
  assign bus.pronto  = r_pronto;
  assign bus.ocupado = r_ocupado;

endmodule
`default_nettype wire
